// File: rtl/mem_port_arbiter_pkg.sv
// Shared state/owner encodings and default word length for mem_port_arbiter.
// Optional feature macro: MEM_PORT_ARB_RR_EN (round-robin arbitration).
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;
endpackage

// File: rtl/mem_port_arb_sel.sv
// Combinational owner picker for mem_port_arbiter.
// MEM_PORT_ARB_RR_EN selects round-robin on ties; otherwise MEM beats IF.
module mem_port_arb_sel
  import mem_port_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   mem_req,
`ifdef MEM_PORT_ARB_RR_EN
  input  owner_t last_grant,
`endif
  output owner_t grant
);

  always_comb begin
    grant = OWN_MEM;
    if (!mem_req) begin
      grant = OWN_IF;
    end
`ifdef MEM_PORT_ARB_RR_EN
    // last_grant holds the owner favoured at the next tie
    else if (if_req) begin
      grant = last_grant;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port external memory between instruction fetch and load/store.
// Optional feature macro: MEM_PORT_ARB_RR_EN (round-robin instead of MEM-first).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = `WORD_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack
);

  arb_state_t        state_reg, state_next;
  owner_t            owner_reg, grant;
  logic              mem_req, start, done;
  logic              if_ready_reg, mem_ready_reg, ext_req_reg, ext_we_reg;
  logic [ADDR_W-1:0] ext_addr_reg;
  logic [DATA_W-1:0] ext_wdata_reg, if_rdata_reg, mem_rdata_reg;

  assign mem_req = mem_rd_en | mem_wr_en;

`ifdef MEM_PORT_ARB_RR_EN
  owner_t last_grant_reg;

  mem_port_arb_sel u_sel (
    .if_req    (if_req),
    .mem_req   (mem_req),
    .last_grant(last_grant_reg),
    .grant     (grant)
  );

  // Favour the other requester at the next tie once an owner is granted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_reg <= OWN_IF;
    end else if (start) begin
      last_grant_reg <= (grant == OWN_IF) ? OWN_MEM : OWN_IF;
    end
  end
`else
  mem_port_arb_sel u_sel (
    .if_req (if_req),
    .mem_req(mem_req),
    .grant  (grant)
  );
`endif

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (if_req || mem_req) begin
          start      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (ext_ack) begin
          done       = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_reg     <= OWN_IF;
      ext_req_reg   <= 1'b0;
      ext_we_reg    <= 1'b0;
      ext_addr_reg  <= '0;
      ext_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
      if_ready_reg  <= 1'b0;
      mem_ready_reg <= 1'b0;
    end else begin
      if_ready_reg  <= 1'b0;
      mem_ready_reg <= 1'b0;
      if (start) begin
        owner_reg     <= grant;
        ext_req_reg   <= 1'b1;
        ext_we_reg    <= (grant == OWN_MEM) && mem_wr_en;
        ext_addr_reg  <= (grant == OWN_MEM) ? mem_addr : if_addr;
        ext_wdata_reg <= (grant == OWN_MEM) ? mem_wdata : '0;
      end
      // Ready only if the owner still wants the result (e.g. not flushed).
      if (done) begin
        ext_req_reg <= 1'b0;
        if (owner_reg == OWN_IF) begin
          if_rdata_reg <= ext_rdata;
          if_ready_reg <= if_req;
        end else begin
          if (!ext_we_reg) begin
            mem_rdata_reg <= ext_rdata;
          end
          mem_ready_reg <= mem_req;
        end
      end
    end
  end

  assign ext_req   = ext_req_reg;
  assign ext_we    = ext_we_reg;
  assign ext_addr  = ext_addr_reg;
  assign ext_wdata = ext_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_rdata = mem_rdata_reg;
  assign if_ready  = if_ready_reg;
  assign mem_ready = mem_ready_reg;
  assign if_stall  = if_req & ~if_ready_reg;
  assign mem_stall = mem_req & ~mem_ready_reg;

endmodule
